// File: rtl/lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lstm_seq_ctrl
// Purpose  : Sequence controller for a single LSTM cell core. It buffers up
//            to SEQ_MAX input vectors and runs one cell step per vector. Each
//            step's result is fed back as the hidden state for the next step.
//            It streams either every step's hidden state or only the final one.
// Ports    : clk, rst                         clock / synchronous reset
//            in_valid/in_ready/in_data/in_last  upstream vector stream
//            carry_h, emit_all                per-sequence mode, taken from
//                                             the first accepted vector
//            cell_start/cell_x/cell_h         cell step request + operands
//            cell_finished/cell_y             cell completion + result
//            out_valid/out_ready/out_data     hidden-state output stream
//            out_step/out_last                step index / final-step flag
//            busy, seq_len                    status
//            err_trunc (pulse), err_timeout (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module lstm_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int SEQ_MAX    = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N*DATA_WIDTH-1:0]        in_data,
    input  logic                           in_last,
    input  logic                           carry_h,
    input  logic                           emit_all,
    output logic                           cell_start,
    output logic [N*DATA_WIDTH-1:0]        cell_x,
    output logic [N*DATA_WIDTH-1:0]        cell_h,
    input  logic                           cell_finished,
    input  logic [N*DATA_WIDTH-1:0]        cell_y,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N*DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(SEQ_MAX)-1:0]     out_step,
    output logic                           out_last,
    output logic                           busy,
    output logic [$clog2(SEQ_MAX+1)-1:0]   seq_len,
    output logic                           err_trunc,
    output logic                           err_timeout
);

    localparam int c_vw = N * DATA_WIDTH;
    localparam int c_tw = $clog2(SEQ_MAX);
    localparam int c_cw = $clog2(SEQ_MAX + 1);
    localparam int c_ww = $clog2(TIMEOUT + 1);

    localparam logic [c_cw-1:0] c_one_cw    = c_cw'(1);
    localparam logic [c_tw-1:0] c_one_tw    = c_tw'(1);
    localparam logic [c_ww-1:0] c_one_ww    = c_ww'(1);
    localparam logic [c_cw-1:0] c_seq_max   = c_cw'(SEQ_MAX);
    localparam logic [c_ww-1:0] c_wdog_last = c_ww'(TIMEOUT - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_issue = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_emit  = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [c_vw-1:0]  r_buf [SEQ_MAX];
    logic [c_cw-1:0]  r_cnt;
    logic [c_tw-1:0]  r_t;
    logic [c_ww-1:0]  r_wdog;
    logic [c_vw-1:0]  r_h;
    logic [c_vw-1:0]  r_cell_x;
    logic [c_vw-1:0]  r_cell_h;
    logic             r_emit_all;
    logic             r_err_trunc;
    logic             r_err_timeout;

    logic [2:0]       w_state_nxt;
    logic [c_cw-1:0]  w_cnt_nxt;
    logic [c_tw-1:0]  w_t_nxt;
    logic [c_ww-1:0]  w_wdog_nxt;
    logic [c_vw-1:0]  w_h_nxt;
    logic             w_emit_all_nxt;
    logic             w_err_trunc_nxt;
    logic             w_err_timeout_nxt;
    logic             w_buf_we;
    logic [c_cw-1:0]  w_buf_widx;
    logic [c_vw-1:0]  w_x_nxt;
    logic             w_accept;
    logic             w_at_last;
    logic [c_cw-1:0]  w_cnt_inc;

    assign in_ready  = !rst && ((r_state == c_st_idle) ||
                                ((r_state == c_st_load) && (r_cnt < c_seq_max)));
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = r_cnt + c_one_cw;
    // The current step is the final one when t == cnt-1, written as t+1 == cnt
    // so that no underflow can occur when cnt is zero.
    assign w_at_last = ((c_cw'(r_t) + c_one_cw) == r_cnt);

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_t_nxt           = r_t;
        w_wdog_nxt        = r_wdog;
        w_h_nxt           = r_h;
        w_emit_all_nxt    = r_emit_all;
        w_err_trunc_nxt   = 1'b0;
        w_err_timeout_nxt = r_err_timeout;
        w_buf_we          = 1'b0;
        w_buf_widx        = r_cnt;

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_buf_we       = 1'b1;
                    w_buf_widx     = '0;
                    w_cnt_nxt      = c_one_cw;
                    w_t_nxt        = '0;
                    w_emit_all_nxt = emit_all;
                    if (!carry_h) begin
                        w_h_nxt = '0;
                    end
                    w_state_nxt = in_last ? c_st_issue : c_st_load;
                end
            end

            c_st_load: begin
                if (w_accept) begin
                    w_buf_we  = 1'b1;
                    w_cnt_nxt = w_cnt_inc;
                    if (in_last) begin
                        w_t_nxt     = '0;
                        w_state_nxt = c_st_issue;
                    end else if (w_cnt_inc == c_seq_max) begin
                        // Buffer full without an end marker: run what we have.
                        w_t_nxt         = '0;
                        w_err_trunc_nxt = 1'b1;
                        w_state_nxt     = c_st_issue;
                    end
                end
            end

            c_st_issue: begin
                w_wdog_nxt  = '0;
                w_state_nxt = c_st_wait;
            end

            c_st_wait: begin
                // A completion on the watchdog's final cycle still counts.
                if (cell_finished) begin
                    w_h_nxt    = cell_y;
                    w_wdog_nxt = '0;
                    if (r_emit_all || w_at_last) begin
                        w_state_nxt = c_st_emit;
                    end else begin
                        w_t_nxt     = r_t + c_one_tw;
                        w_state_nxt = c_st_issue;
                    end
                end else if (r_wdog == c_wdog_last) begin
                    w_err_timeout_nxt = 1'b1;
                    w_cnt_nxt         = '0;
                    w_t_nxt           = '0;
                    w_wdog_nxt        = '0;
                    w_state_nxt       = c_st_idle;
                end else begin
                    w_wdog_nxt = r_wdog + c_one_ww;
                end
            end

            c_st_emit: begin
                if (out_ready) begin
                    if (w_at_last) begin
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_t_nxt     = r_t + c_one_tw;
                        w_state_nxt = c_st_issue;
                    end
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Operand for the step being issued. A single-vector sequence goes to
    // ISSUE on the same edge that writes buf[0], so bypass the buffer then.
    assign w_x_nxt = (r_state == c_st_idle) ? in_data : r_buf[w_t_nxt];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_t           <= '0;
            r_wdog        <= '0;
            r_h           <= '0;
            r_cell_x      <= '0;
            r_cell_h      <= '0;
            r_emit_all    <= 1'b0;
            r_err_trunc   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_t           <= w_t_nxt;
            r_wdog        <= w_wdog_nxt;
            r_h           <= w_h_nxt;
            r_emit_all    <= w_emit_all_nxt;
            r_err_trunc   <= w_err_trunc_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            // Operands are captured only on entry to ISSUE, so they stay
            // stable for the whole cell step.
            if (w_state_nxt == c_st_issue) begin
                r_cell_x <= w_x_nxt;
                r_cell_h <= w_h_nxt;
            end
        end
    end

    // Vector buffer; contents need no reset since cnt gates their use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SEQ_MAX; i++) begin
            if (w_buf_we && (w_buf_widx == c_cw'(i))) begin
                r_buf[i] <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cell_start  = (r_state == c_st_issue);
    assign cell_x      = r_cell_x;
    assign cell_h      = r_cell_h;
    assign out_valid   = (r_state == c_st_emit);
    assign out_data    = r_h;
    assign out_step    = r_t;
    assign out_last    = out_valid && w_at_last;
    assign busy        = (r_state != c_st_idle);
    assign seq_len     = r_cnt;
    assign err_trunc   = r_err_trunc;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire
